// File: rtl/mips_sequencer_pkg.sv
// Shared definitions for the MIPS multi-cycle sequencer: opcodes, FSM states,
// next-PC select codes and the default reset PC.
package mips_sequencer_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } stateT;

  typedef enum logic [1:0] {
    PC_HOLD   = 2'd0,
    PC_INC    = 2'd1,
    PC_BRANCH = 2'd2,
    PC_JUMP   = 2'd3
  } pcSelT;

  function automatic logic isSupported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LUI) ||
           (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_sequencer_pc_unit.sv
// Program counter register with next-PC selection (hold / +4 / branch / jump).
// Branch offsets are relative to the already-incremented PC.
module pc_unit
  import mips_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  pcSelT       pcSel,
  input  logic [25:0] irField,
  output logic [31:0] pc
);

  logic [31:0] pcNext;
  logic [31:0] branchOffset;

  assign branchOffset = {{14{irField[15]}}, irField[15:0], 2'b00};

  always_comb begin
    pcNext = pc;
    case (pcSel)
      PC_INC:    pcNext = pc + 32'd4;
      PC_BRANCH: pcNext = pc + branchOffset;
      PC_JUMP:   pcNext = {pc[31:28], irField, 2'b00};
      default:   pcNext = pc;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) pc <= RESET_PC;
    else       pc <= pcNext;
  end

endmodule

// File: rtl/mips_sequencer.sv
// Multi-cycle MIPS control sequencer: FETCH/DECODE/EXEC/MEM/WB FSM, instruction
// register, sticky illegal flag and retired-instruction counter.
module mips_sequencer
  import mips_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] imemData,
  input  logic        imemReady,
  input  logic        dmemReady,
  input  logic        aluZero,
  output logic [31:0] pc,
  output logic        imemReq,
  output logic [31:0] ir,
  output logic        dmemReq,
  output logic        memRead,
  output logic        memWrite,
  output logic        regWrite,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [31:0] retired
);

  // Handshake: a request (imemReq/dmemReq) is held for as long as the FSM sits
  // in FETCH/MEM; the transfer completes on the rising edge where the matching
  // ready is high. Ready inputs are ignored while their request is low.

  stateT      stateQ, stateNext;
  pcSelT      pcSel;
  logic       irLoad;
  logic       retire;
  logic       setIllegal;
  logic [5:0] opcode;

  assign opcode = ir[31:26];
  assign state  = stateQ;

  pc_unit #(.RESET_PC(RESET_PC)) uPcUnit (
    .clock   (clock),
    .reset   (reset),
    .pcSel   (pcSel),
    .irField (ir[25:0]),
    .pc      (pc)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateQ  <= ST_FETCH;
      ir      <= 32'd0;
      illegal <= 1'b0;
      retired <= 32'd0;
    end else begin
      stateQ <= stateNext;
      if (irLoad)     ir      <= imemData;
      if (setIllegal) illegal <= 1'b1;
      if (retire)     retired <= retired + 32'd1;
    end
  end

  always_comb begin
    stateNext  = stateQ;
    pcSel      = PC_HOLD;
    irLoad     = 1'b0;
    retire     = 1'b0;
    setIllegal = 1'b0;
    case (stateQ)
      ST_FETCH: begin
        if (imemReady) begin
          irLoad    = 1'b1;
          pcSel     = PC_INC;
          stateNext = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // Unsupported opcodes retire here as a NOP.
        if (!isSupported(opcode)) begin
          setIllegal = 1'b1;
          retire     = 1'b1;
          stateNext  = ST_FETCH;
        end else begin
          stateNext = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (opcode)
          OP_LW, OP_SW: stateNext = ST_MEM;
          OP_BEQ: begin
            if (aluZero) pcSel = PC_BRANCH;
            retire    = 1'b1;
            stateNext = ST_FETCH;
          end
          OP_J: begin
            pcSel     = PC_JUMP;
            retire    = 1'b1;
            stateNext = ST_FETCH;
          end
          default: stateNext = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (dmemReady) begin
          if (opcode == OP_LW) begin
            stateNext = ST_WB;
          end else begin
            retire    = 1'b1;
            stateNext = ST_FETCH;
          end
        end
      end
      ST_WB: begin
        retire    = 1'b1;
        stateNext = ST_FETCH;
      end
      default: stateNext = ST_FETCH;
    endcase
  end

  assign imemReq  = (stateQ == ST_FETCH);
  assign dmemReq  = (stateQ == ST_MEM);
  assign memRead  = dmemReq && (opcode == OP_LW);
  assign memWrite = dmemReq && (opcode == OP_SW);
  assign regWrite = (stateQ == ST_WB);

endmodule

// File: tb/tb_mips_sequencer.sv
// Directed and randomized checks of mips_sequencer against an instruction-level
// model of PC, latency, strobes, retired count and the illegal flag.
module tb_mips_sequencer;

  logic        clock;
  logic        reset;
  logic [31:0] imemData;
  logic        imemReady;
  logic        dmemReady;
  logic        aluZero;
  logic [31:0] pc;
  logic        imemReq;
  logic [31:0] ir;
  logic        dmemReq;
  logic        memRead;
  logic        memWrite;
  logic        regWrite;
  logic [2:0]  state;
  logic        illegal;
  logic [31:0] retired;

  // Second instance with a high reset PC, for jumps that keep pc[31:28].
  logic [31:0] hiPc;
  logic        hiImemReq;
  logic [31:0] hiIr;
  logic        hiDmemReq;
  logic        hiMemRead;
  logic        hiMemWrite;
  logic        hiRegWrite;
  logic [2:0]  hiState;
  logic        hiIllegal;
  logic [31:0] hiRetired;

  int vectors = 0;
  int miscompares = 0;

  mips_sequencer dut (
    .clock(clock), .reset(reset), .imemData(imemData), .imemReady(imemReady),
    .dmemReady(dmemReady), .aluZero(aluZero), .pc(pc), .imemReq(imemReq),
    .ir(ir), .dmemReq(dmemReq), .memRead(memRead), .memWrite(memWrite),
    .regWrite(regWrite), .state(state), .illegal(illegal), .retired(retired)
  );

  mips_sequencer #(.RESET_PC(32'h1000_0000)) dutHi (
    .clock(clock), .reset(reset), .imemData(imemData), .imemReady(imemReady),
    .dmemReady(dmemReady), .aluZero(aluZero), .pc(hiPc), .imemReq(hiImemReq),
    .ir(hiIr), .dmemReq(hiDmemReq), .memRead(hiMemRead), .memWrite(hiMemWrite),
    .regWrite(hiRegWrite), .state(hiState), .illegal(hiIllegal), .retired(hiRetired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one instruction from FETCH until retired changes, recording what the
  // DUT did each cycle. Inputs change at negedge, outputs sampled there too.
  task automatic run_instr(input logic [31:0] instr, input int iw, input int dw,
                           input logic z, output int cyc, output int rwCnt,
                           output int rwAt, output int rdCnt, output int wrCnt,
                           output int dreqCnt, output logic pcMoved,
                           output logic timeout);
    logic [31:0] startRet, startPc;
    int fc, dc;
    startRet = retired; startPc = pc;
    cyc = 0; rwCnt = 0; rwAt = -1; rdCnt = 0; wrCnt = 0; dreqCnt = 0;
    pcMoved = 1'b0; timeout = 1'b1; fc = 0; dc = 0;
    imemData = instr; aluZero = z;
    while (cyc < 40) begin
      @(negedge clock);
      if (imemReq && pc !== startPc) pcMoved = 1'b1;
      if (regWrite) begin rwCnt++; rwAt = cyc; end
      if (dmemReq) dreqCnt++;
      if (memRead) rdCnt++;
      if (memWrite) wrCnt++;
      imemReady = imemReq ? (fc == iw) : 1'($urandom_range(0, 1));
      dmemReady = dmemReq ? (dc == dw) : 1'($urandom_range(0, 1));
      if (imemReq) fc++;
      if (dmemReq) dc++;
      @(posedge clock);
      #1;
      cyc++;
      if (retired !== startRet) begin timeout = 1'b0; break; end
    end
    @(negedge clock);
    imemReady = 1'b0; dmemReady = 1'b0;
  endtask

  function automatic int base_cycles(input logic [5:0] op);
    case (op)
      6'b000100, 6'b000010:                       return 3;
      6'b000000, 6'b001000, 6'b001111, 6'b101011: return 4;
      6'b100011:                                  return 5;
      default:                                    return 2;
    endcase
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b001000, 6'b001111, 6'b100011,
                      6'b101011, 6'b000100, 6'b000010};
  endfunction

  function automatic logic [31:0] model_next_pc(input logic [31:0] cur,
                                                input logic [31:0] instr,
                                                input logic z);
    logic [31:0] seq;
    seq = cur + 32'd4;
    if (instr[31:26] == 6'b000100 && z)
      return seq + {{14{instr[15]}}, instr[15:0], 2'b00};
    if (instr[31:26] == 6'b000010)
      return {seq[31:28], instr[25:0], 2'b00};
    return seq;
  endfunction

  int cyc, rwCnt, rwAt, rdCnt, wrCnt, dreqCnt;
  logic pcMoved, timeout;

  initial begin
    logic [5:0] opTable [9];
    logic [31:0] modelPc, modelRet, r, instr;
    logic modelIll, z, found;
    int rwSeen, iw, dw;
    opTable = '{6'b000000, 6'b001000, 6'b001111, 6'b100011, 6'b101011,
                6'b000100, 6'b000010, 6'b111111, 6'b010101};

    reset = 1'b1; imemData = 32'd0; imemReady = 1'b0; dmemReady = 1'b0; aluZero = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_pc", pc, 32'h0);
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_imemReq", {31'd0, imemReq}, 32'd1);
    chk("rst_strobes", {28'd0, dmemReq, memRead, memWrite, regWrite}, 32'd0);
    chk("rst_hi_pc", hiPc, 32'h1000_0000);
    reset = 1'b0;

    // j from both instances: low one lands at 0x100, high one keeps pc[31:28].
    run_instr(32'h0800_0040, 0, 0, 1'b0, cyc, rwCnt, rwAt, rdCnt, wrCnt, dreqCnt, pcMoved, timeout);
    chk("j_timeout", {31'd0, timeout}, 32'd0);
    chk("j_cycles", cyc, 3);
    chk("j_pc", pc, 32'h0000_0100);
    chk("j_hi_pc", hiPc, 32'h1000_0100);
    chk("j_strobes", rwCnt + dreqCnt, 0);

    run_instr(32'h1000_FFFF, 0, 0, 1'b1, cyc, rwCnt, rwAt, rdCnt, wrCnt, dreqCnt, pcMoved, timeout);
    chk("beq_taken_cycles", cyc, 3);
    chk("beq_taken_pc", pc, 32'h0000_0100);
    run_instr(32'h1000_FFFF, 0, 0, 1'b0, cyc, rwCnt, rwAt, rdCnt, wrCnt, dreqCnt, pcMoved, timeout);
    chk("beq_nt_pc", pc, 32'h0000_0104);
    chk("beq_retired", retired, 32'd3);

    // R-type interrupted by reset as soon as it reaches WB.
    imemData = 32'h0022_5020; rwSeen = 0; found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clock);
      if (regWrite) rwSeen++;
      imemReady = imemReq;
      dmemReady = 1'b0;
      @(posedge clock);
      #1;
      if (state == 3'd4) begin reset = 1'b1; found = 1'b1; end
    end
    @(negedge clock);
    chk("wbrst_reached", {31'd0, found}, 32'd1);
    chk("wbrst_regWrite", {31'd0, regWrite}, 32'd0);
    chk("wbrst_seen", rwSeen, 0);
    chk("wbrst_pc", pc, 32'h0);
    chk("wbrst_state", {29'd0, state}, 32'd0);
    chk("wbrst_retired", retired, 32'd0);
    imemReady = 1'b0;
    reset = 1'b0;

    run_instr(32'h2022_0005, 3, 0, 1'b0, cyc, rwCnt, rwAt, rdCnt, wrCnt, dreqCnt, pcMoved, timeout);
    chk("addi_pc_held", {31'd0, pcMoved}, 32'd0);
    chk("addi_pc", pc, 32'h4);
    chk("addi_rw_count", rwCnt, 1);
    chk("addi_rw_at", rwAt, 6);
    chk("addi_retired", retired, 32'd1);

    run_instr(32'h8C22_0008, 0, 2, 1'b0, cyc, rwCnt, rwAt, rdCnt, wrCnt, dreqCnt, pcMoved, timeout);
    chk("lw_cycles", cyc, 7);
    chk("lw_dmemReq", dreqCnt, 3);
    chk("lw_memRead", rdCnt, 3);
    chk("lw_memWrite", wrCnt, 0);
    chk("lw_rw_at", rwAt, 6);

    run_instr(32'hFC00_0000, 0, 0, 1'b0, cyc, rwCnt, rwAt, rdCnt, wrCnt, dreqCnt, pcMoved, timeout);
    chk("ill_flag", {31'd0, illegal}, 32'd1);
    chk("ill_retired", retired, 32'd3);
    chk("ill_strobes", rwCnt + dreqCnt, 0);
    chk("ill_cycles", cyc, 2);
    run_instr(32'h3C01_1234, 0, 0, 1'b0, cyc, rwCnt, rwAt, rdCnt, wrCnt, dreqCnt, pcMoved, timeout);
    chk("ill_sticky", {31'd0, illegal}, 32'd1);
    chk("lui_rw_count", rwCnt, 1);

    modelPc = pc; modelRet = retired; modelIll = illegal;
    for (int i = 0; i < 150; i++) begin
      r = $urandom();
      instr = {opTable[$urandom_range(0, 8)], r[25:0]};
      iw = $urandom_range(0, 3);
      dw = $urandom_range(0, 3);
      z = 1'($urandom_range(0, 1));
      run_instr(instr, iw, dw, z, cyc, rwCnt, rwAt, rdCnt, wrCnt, dreqCnt, pcMoved, timeout);
      modelPc = is_legal(instr[31:26]) ? model_next_pc(modelPc, instr, z) : modelPc + 32'd4;
      modelRet = modelRet + 32'd1;
      if (!is_legal(instr[31:26])) modelIll = 1'b1;
      chk("rnd_timeout", {31'd0, timeout}, 32'd0);
      chk("rnd_cycles", cyc, base_cycles(instr[31:26]) + iw +
          ((instr[31:26] == 6'b100011 || instr[31:26] == 6'b101011) ? dw : 0));
      chk("rnd_pc", pc, modelPc);
      chk("rnd_retired", retired, modelRet);
      chk("rnd_illegal", {31'd0, illegal}, {31'd0, modelIll});
      chk("rnd_regWrite", rwCnt,
          (instr[31:26] inside {6'b000000, 6'b001000, 6'b001111, 6'b100011}) ? 1 : 0);
      chk("rnd_memRead", rdCnt, (instr[31:26] == 6'b100011) ? dw + 1 : 0);
      chk("rnd_memWrite", wrCnt, (instr[31:26] == 6'b101011) ? dw + 1 : 0);
      chk("rnd_pc_held", {31'd0, pcMoved}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
